// File: rtl/npu_mm_ctrl.sv
// npu_mm_ctrl: sequences one NxN signed matrix product C = A x B through operand/result buffers.
// Optional saturation of results is enabled by defining NPU_MM_CTRL_SAT_EN.
module npu_mm_ctrl #(
  parameter int data_size = 32,
  parameter int N         = 3,
  parameter int ADDR_W    = 4,
  parameter int ACC_W     = 2*data_size+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 a_re,
  output logic [ADDR_W-1:0]    a_addr,
  input  logic [data_size-1:0] a_rdata,
  output logic                 b_re,
  output logic [ADDR_W-1:0]    b_addr,
  input  logic [data_size-1:0] b_rdata,
  output logic                 c_we,
  output logic [ADDR_W-1:0]    c_addr,
  output logic [data_size-1:0] c_wdata,
  output logic                 busy,
  output logic                 sat_flag,
  output logic                 ack
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] NA  = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] NM1 = ADDR_W'(N-1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic rd_vld_q, first_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [2*data_size-1:0] prod;
  logic [data_size-1:0] res;
  logic start;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (en) begin
        state_d = RUN;
        i_d = '0;
        j_d = '0;
        k_d = '0;
      end
      RUN: begin
        k_d = k_q + 1'b1;
        state_d = (k_q == NM1) ? DRAIN : RUN;
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        k_d = '0;
        j_d = (j_q == NM1) ? '0 : j_q + 1'b1;
        i_d = (j_q == NM1) ? i_q + 1'b1 : i_q;
        state_d = (i_q == NM1 && j_q == NM1) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end
  assign start   = state_q == IDLE && en;
  assign a_re    = state_q == RUN;
  assign b_re    = a_re;
  assign a_addr  = a_re ? i_q*NA + k_q : '0;
  assign b_addr  = b_re ? k_q*NA + j_q : '0;
  assign c_we    = state_q == WRITE;
  assign c_addr  = c_we ? i_q*NA + j_q : '0;
  assign c_wdata = c_we ? res : '0;
  assign busy    = state_q == RUN || state_q == DRAIN || state_q == WRITE;
  assign ack     = state_q == DONE;
  assign prod    = $signed(a_rdata) * $signed(b_rdata);
  // The k==0 term overwrites acc, so no separate clear cycle is needed between elements.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      first_q <= 1'b0;
      acc_q <= '0;
    end else begin
      rd_vld_q <= a_re;
      first_q <= a_re && k_q == '0;
      if (rd_vld_q) acc_q <= (first_q ? '0 : acc_q) + ACC_W'(prod);
    end
  end
`ifdef NPU_MM_CTRL_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-data_size+1){1'b0}}, {(data_size-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  logic hi, lo, sat_q;
  assign hi  = acc_q > MAXV;
  assign lo  = acc_q < MINV;
  assign res = hi ? {1'b0, {(data_size-1){1'b1}}} : lo ? {1'b1, {(data_size-1){1'b0}}} : acc_q[data_size-1:0];
  always_ff @(posedge clk) begin
    if (rst || start) sat_q <= 1'b0;
    else if (c_we && (hi || lo)) sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;
`else
  assign res = acc_q[data_size-1:0];
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_npu_mm_ctrl.sv
// tb_npu_mm_ctrl: randomized self-checking bench comparing each run against a direct matrix-product model.
module tb_npu_mm_ctrl;
  logic clk = 0, rst = 1, en = 0;
  logic a_re, b_re, c_we, busy, sat_flag, ack;
  logic [3:0] a_addr, b_addr, c_addr;
  logic [31:0] a_rdata = 0, b_rdata = 0, c_wdata;
  logic [31:0] ma [9];
  logic [31:0] mb [9];
  int nchk = 0, nerr = 0;
  logic [49:0] allout;
  assign allout = {a_re, a_addr, b_re, b_addr, c_we, c_addr, c_wdata, busy, sat_flag, ack};
  npu_mm_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_re(b_re), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .busy(busy), .sat_flag(sat_flag), .ack(ack)
  );
  always #5 clk = ~clk;
  // Buffers answer one cycle after the strobe; idle cycles return noise.
  always @(posedge clk) begin
    a_rdata <= a_re ? ma[a_addr] : $urandom;
    b_rdata <= b_re ? mb[b_addr] : $urandom;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic signed [67:0] dot(input int idx);
    logic signed [67:0] s = 0, x, y;
    for (int k = 0; k < 3; k++) begin
      x = $signed(ma[(idx/3)*3+k]);
      y = $signed(mb[k*3+idx%3]);
      s += x * y;
    end
    return s;
  endfunction
  function automatic logic [31:0] exp_c(input int idx);
    logic signed [67:0] s = dot(idx);
`ifdef NPU_MM_CTRL_SAT_EN
    if (s > 68'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -68'sh80000000) return 32'h80000000;
`endif
    return s[31:0];
  endfunction
  function automatic logic exp_sat();
`ifdef NPU_MM_CTRL_SAT_EN
    for (int n = 0; n < 9; n++)
      if (dot(n) > 68'sh7FFFFFFF || dot(n) < -68'sh80000000) return 1'b1;
`endif
    return 1'b0;
  endfunction
  task automatic start(input bit hold);
    @(negedge clk) en = 1;
    @(negedge clk) if (!hold) en = 0;
  endtask
  task automatic observe(input int first);
    int nw = 0, busybad = 0, ackbad = 0;
    for (int cyc = first; cyc <= 46; cyc++) begin
      if (c_we) begin
        if (nw < 9) begin
          chk("c_addr", c_addr, nw);
          chk("c_wdata", c_wdata, exp_c(nw));
        end
        nw++;
      end
      if (busy !== (cyc <= 45)) busybad++;
      if (ack && cyc != 46) ackbad++;
      if (cyc == 46) chk("ack46", ack, 1);
      if (cyc < 46) @(negedge clk);
    end
    chk("nwrites", nw, 9);
    chk("busy_bad_cycles", busybad, 0);
    chk("early_ack", ackbad, 0);
    chk("sat_flag", sat_flag, exp_sat());
  endtask
  task automatic fill(input int mode);
    for (int n = 0; n < 9; n++) begin
      case (mode)
        0: begin ma[n] = (n % 4 == 0) ? 1 : 0; mb[n] = n + 1; end
        1: begin ma[n] = 32'hFFFFFFFF; mb[n] = 2; end
        2: begin ma[n] = 32'h7FFFFFFF; mb[n] = 2; end
        3: begin ma[n] = 32'h80000000; mb[n] = 32'h80000000; end
        4: begin ma[n] = $urandom_range(0, 2000) - 1000; mb[n] = $urandom_range(0, 2000) - 1000; end
        default: begin ma[n] = $urandom; mb[n] = $urandom; end
      endcase
    end
  endtask
  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("reset_outputs", allout, 0);
    rst = 0;
    @(negedge clk) chk("idle_outputs", allout, 0);
    fill(0);
    start(0);
    observe(1);
    for (int n = 0; n < 9; n++) chk("identity_model", exp_c(n), n + 1);
    fill(1);
    start(0);
    observe(1);
    chk("neg_model", exp_c(4), 32'hFFFFFFFA);
    fill(2);
    start(0);
    observe(1);
    chk("acc_model", dot(0), 68'sh2FFFFFFFA);
    fill(3);
    start(0);
    observe(1);
    for (int r = 0; r < 6; r++) begin
      fill(4 + r % 2);
      start(0);
      observe(1);
    end
    fill(5);
    start(1);
    observe(1);
    @(negedge clk) chk("hold_idle_re", {a_re, busy}, 2'b00);
    @(negedge clk) chk("hold_restart_re", {a_re, busy}, 2'b11);
    @(negedge clk);
    observe(2);
    en = 0;
    fill(5);
    start(0);
    repeat (19) @(negedge clk);
    rst = 1;
    @(negedge clk) chk("midrun_reset_outputs", allout, 0);
    rst = 0;
    bad = 0;
    repeat (60) @(negedge clk) if (c_we || ack || busy) bad++;
    chk("after_abort_quiet", bad, 0);
    fill(5);
    start(0);
    observe(1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
